// File: rtl/vector_mac_mmio_if.sv
// CPU-side control signals for the memory-mapped dot-product engine.
// The tri-state data bus and readDone stay plain ports on the engine itself.
interface vector_mac_mmio_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] address;
   logic              writeEn;
   logic              outputEn;
   logic              done_irq;

   modport master (
      output address,
      output writeEn,
      output outputEn,
      input  done_irq
   );

   modport slave (
      input  address,
      input  writeEn,
      input  outputEn,
      output done_irq
   );
endinterface

// File: rtl/vector_mac_mmio.sv
// Memory-mapped N-element signed dot-product engine, one MAC per cycle.
// Define VMAC_SATURATE_EN to clamp the final sum instead of wrapping it.
module vector_mac_mmio #(
   parameter int                ADDR_W = 32,
   parameter int                DATA_W = 16,
   parameter int                N      = 8,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   inout  wire  [DATA_W-1:0]    BUS,
   output wire                  readDone,
   vector_mac_mmio_if.slave     cpu_if
);

   localparam int IDX_W = $clog2(N);
   localparam int RES_W = 2 * DATA_W;
   localparam int ACC_W = RES_W + $clog2(N);

   localparam logic [ADDR_W-1:0] OFF_B    = ADDR_W'(N);
   localparam logic [ADDR_W-1:0] OFF_CTRL = ADDR_W'(2 * N);
   localparam logic [ADDR_W-1:0] OFF_LO   = ADDR_W'(2 * N + 1);
   localparam logic [ADDR_W-1:0] OFF_HI   = ADDR_W'(2 * N + 2);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t                    r_state;
   logic [DATA_W-1:0]         r_a [N];
   logic [DATA_W-1:0]         r_b [N];
   logic signed [ACC_W-1:0]   r_acc;
   logic [IDX_W-1:0]          r_idx;
   logic [RES_W-1:0]          r_result;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_irq;
   logic                      r_read_done;

   logic [ADDR_W-1:0]         w_offset;
   logic                      w_cs;
   logic                      w_sel_a;
   logic                      w_sel_b;
   logic                      w_sel_ctrl;
   logic                      w_wr;
   logic [IDX_W-1:0]          w_a_idx;
   logic [IDX_W-1:0]          w_b_idx;
   logic [DATA_W-1:0]         w_rdata;
   logic signed [RES_W-1:0]   w_a_ext;
   logic signed [RES_W-1:0]   w_b_ext;
   logic signed [RES_W-1:0]   w_prod;
   logic signed [ACC_W-1:0]   w_acc_next;
   logic [RES_W-1:0]          w_final;

   // Unsigned subtraction wraps addresses below BASE to huge offsets, so one compare decodes the window.
   assign w_offset   = cpu_if.address - BASE;
   assign w_cs       = (w_offset <= OFF_HI);
   assign w_sel_a    = (w_offset < OFF_B);
   assign w_sel_b    = !w_sel_a && (w_offset < OFF_CTRL);
   assign w_sel_ctrl = (w_offset == OFF_CTRL);
   assign w_wr       = cpu_if.writeEn && w_cs;
   assign w_a_idx    = w_offset[IDX_W-1:0];
   assign w_b_idx    = IDX_W'(w_offset - OFF_B);

   assign w_a_ext    = {{DATA_W{r_a[r_idx][DATA_W-1]}}, r_a[r_idx]};
   assign w_b_ext    = {{DATA_W{r_b[r_idx][DATA_W-1]}}, r_b[r_idx]};
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_acc_next = r_acc + {{(ACC_W-RES_W){w_prod[RES_W-1]}}, w_prod};

`ifdef VMAC_SATURATE_EN
   logic w_ovf;

   // The sum fits in RES_W bits only when every bit above the result sign bit matches it.
   assign w_ovf   = !((&w_acc_next[ACC_W-1:RES_W-1]) || !(|w_acc_next[ACC_W-1:RES_W-1]));
   assign w_final = !w_ovf                ? w_acc_next[RES_W-1:0]
                  : w_acc_next[ACC_W-1]   ? {1'b1, {(RES_W-1){1'b0}}}
                  :                         {1'b0, {(RES_W-1){1'b1}}};
`else
   assign w_final = w_acc_next[RES_W-1:0];
`endif

   // NOTE: give every always_comb output a default first so no path can infer a latch.
   always_comb begin
      w_rdata = '0;
      if (w_sel_a)
         w_rdata = r_a[w_a_idx];
      else if (w_sel_b)
         w_rdata = r_b[w_b_idx];
      else if (w_sel_ctrl)
         w_rdata = {{(DATA_W-2){1'b0}}, r_done, r_busy};
      else if (w_offset == OFF_LO)
         w_rdata = r_result[DATA_W-1:0];
      else if (w_offset == OFF_HI)
         w_rdata = r_result[RES_W-1:DATA_W];
   end

   assign BUS             = (cpu_if.outputEn && w_cs) ? w_rdata : {DATA_W{1'bz}};
   assign readDone        = w_cs ? r_read_done : 1'bz;
   assign cpu_if.done_irq = r_irq;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_idx       <= '0;
         r_result    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_irq       <= 1'b0;
         r_read_done <= 1'b0;
         // NOTE: the operand arrays are architecturally visible after reset, so they are cleared here.
         for (int i = 0; i < N; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
         end
      end else begin
         r_read_done <= w_cs && !cpu_if.writeEn;
         r_irq       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_wr && w_sel_a)
                  r_a[w_a_idx] <= BUS;
               if (w_wr && w_sel_b)
                  r_b[w_b_idx] <= BUS;
               if (w_wr && w_sel_ctrl && BUS[0]) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + 1'b1;
               if (r_idx == IDX_W'(N - 1)) begin
                  r_result <= w_final;
                  r_done   <= 1'b1;
                  r_irq    <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_mac_mmio.sv
// Directed bench for vector_mac_mmio: results are queued at each start and checked at each done_irq.
// Undriven BUS floats high and undriven readDone floats low, so tri-state shows up as those values.
module tb_vector_mac_mmio;

   localparam int          N      = 8;
   localparam int          DW     = 16;
   localparam int          AW     = 32;
   localparam logic [31:0] BASE   = 32'h100;
   localparam logic [31:0] A_ADDR = BASE;
   localparam logic [31:0] B_ADDR = BASE + N;
   localparam logic [31:0] CTRL   = BASE + 2 * N;
   localparam logic [31:0] RES_LO = BASE + 2 * N + 1;
   localparam logic [31:0] RES_HI = BASE + 2 * N + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   tri1 [DW-1:0]  bus;
   tri0           read_done;
   logic          drv_en = 1'b0;
   logic [DW-1:0] drv = '0;

   assign bus = drv_en ? drv : {DW{1'bz}};

   vector_mac_mmio_if #(.ADDR_W(AW)) cpu ();

   vector_mac_mmio #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .N      (N),
      .BASE   (BASE)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .BUS      (bus),
      .readDone (read_done),
      .cpu_if   (cpu)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int unsigned irq_count    = 0;
   int unsigned last_irq_cyc = 0;
   int unsigned start_cyc    = 0;
   int unsigned irq_base     = 0;
   logic [31:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cpu.done_irq === 1'b1) begin
         irq_count    <= irq_count + 1;
         last_irq_cyc <= cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      cpu.address = a;
      cpu.writeEn = 1'b1;
      drv         = d;
      drv_en      = 1'b1;
      @(negedge clk);
      cpu.writeEn = 1'b0;
      drv_en      = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [DW-1:0] d, output logic rdone);
      @(negedge clk);
      cpu.address  = a;
      cpu.outputEn = 1'b1;
      #1 d = bus;
      @(negedge clk);
      rdone        = read_done;
      cpu.outputEn = 1'b0;
   endtask

   task automatic start_run(input logic [31:0] expected);
      exp_q.push_back(expected);
      irq_base = irq_count;
      wr(CTRL, 16'h0001);
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag);
      logic [DW-1:0] lo, hi, st;
      logic          rdn;
      logic [31:0]   expected;
      int            k;
      k = 0;
      while (irq_count == irq_base && k < 100) begin
         @(posedge clk);
         k++;
      end
      check({tag, "_irq_seen"}, 64'(irq_count - irq_base), 64'd1);
      check({tag, "_latency"}, 64'(last_irq_cyc - start_cyc), 64'(N));
      rd(CTRL, st, rdn);
      check({tag, "_status_done"}, 64'(st), 64'h2);
      expected = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      rd(RES_LO, lo, rdn);
      rd(RES_HI, hi, rdn);
      check({tag, "_result"}, 64'({hi, lo}), 64'(expected));
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          rdn;

      cpu.address  = '0;
      cpu.writeEn  = 1'b0;
      cpu.outputEn = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("reset_irq", 64'(cpu.done_irq), 64'd0);
      rd(CTRL, d, rdn);
      check("reset_status", 64'(d), 64'h0);
      rd(RES_LO, d, rdn);
      check("reset_res_lo", 64'(d), 64'h0);

      // Test 1: A=1..8, B=1
      for (int i = 0; i < N; i++) wr(A_ADDR + 32'(i), 16'(i + 1));
      for (int i = 0; i < N; i++) wr(B_ADDR + 32'(i), 16'h0001);
      rd(A_ADDR + 32'd5, d, rdn);
      check("t1_a5_readback", 64'(d), 64'h6);
      start_run(32'h0000_0024);
      rd(CTRL, d, rdn);
      check("t1_status_busy", 64'(d), 64'h1);
      wait_done("t1");

      // Writes to result registers are ignored
      wr(RES_LO, 16'hBEEF);
      rd(RES_LO, d, rdn);
      check("res_lo_write_ignored", 64'(d), 64'h0024);

      // Test 2: single negative product
      for (int i = 0; i < N; i++) wr(A_ADDR + 32'(i), (i == 0) ? 16'hFFFD : 16'h0000);
      for (int i = 0; i < N; i++) wr(B_ADDR + 32'(i), (i == 0) ? 16'h0005 : 16'h0000);
      start_run(32'hFFFF_FFF1);
      wait_done("t2");

      // Test 3: full-scale positive operands overflow the 32-bit result
      for (int i = 0; i < N; i++) wr(A_ADDR + 32'(i), 16'h7FFF);
      for (int i = 0; i < N; i++) wr(B_ADDR + 32'(i), 16'h7FFF);
`ifdef VMAC_SATURATE_EN
      start_run(32'h7FFF_FFFF);
`else
      start_run(32'hFFF8_0008);
`endif
      wait_done("t3");

      // Test 4: writes during a run are ignored, old result stays readable
      for (int i = 0; i < N; i++) wr(A_ADDR + 32'(i), 16'(i + 1));
      for (int i = 0; i < N; i++) wr(B_ADDR + 32'(i), 16'h0001);
      start_run(32'h0000_0024);
      rd(RES_LO, d, rdn);
`ifdef VMAC_SATURATE_EN
      check("t4_old_res_lo", 64'(d), 64'hFFFF);
`else
      check("t4_old_res_lo", 64'(d), 64'h0008);
`endif
      wr(A_ADDR, 16'h1234);
      wr(CTRL, 16'h0001);
      wait_done("t4");
      repeat (12) @(negedge clk);
      check("t4_single_irq", 64'(irq_count - irq_base), 64'd1);
      rd(A_ADDR, d, rdn);
      check("t4_a0_unchanged", 64'(d), 64'h1);

      // Test 6: window boundaries
      rd(BASE - 32'd1, d, rdn);
      check("t6_below_bus_z", 64'(d), 64'hFFFF);
      check("t6_below_rdone_z", 64'(rdn), 64'd0);
      rd(BASE + 32'(2 * N + 3), d, rdn);
      check("t6_above_bus_z", 64'(d), 64'hFFFF);
      check("t6_above_rdone_z", 64'(rdn), 64'd0);
      rd(CTRL, d, rdn);
      check("t6_status_bus", 64'(d), 64'h2);
      check("t6_read_done", 64'(rdn), 64'd1);

      // Test 5: reset mid-run aborts everything
      start_run(32'h0000_0024);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (15) @(negedge clk);
      check("t5_no_irq", 64'(irq_count - irq_base), 64'd0);
      rd(CTRL, d, rdn);
      check("t5_status", 64'(d), 64'h0);
      rd(RES_LO, d, rdn);
      check("t5_res_lo", 64'(d), 64'h0);
      rd(RES_HI, d, rdn);
      check("t5_res_hi", 64'(d), 64'h0);
      for (int i = 0; i < N; i++) begin
         rd(A_ADDR + 32'(i), d, rdn);
         check($sformatf("t5_a%0d", i), 64'(d), 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
